// File: rtl/xgmii_frame_generator.sv
// XGMII-style Ethernet frame generator: LANES bytes per cycle with per-lane
// control flags. Emits start/preamble/SFD, a patterned payload, terminate,
// and a minimum inter-packet gap. Supports abort injection and back-to-back frames.
module xgmii_frame_generator #(
  parameter int          LANES         = 8,
  parameter int          MIN_LEN       = 46,
  parameter int          MAX_LEN       = 1500,
  parameter int          IPG_BYTES     = 12,
  parameter logic [7:0]  IDLE_CODE     = 8'h07,
  parameter logic [7:0]  START_CODE    = 8'hFB,
  parameter logic [7:0]  TERM_CODE     = 8'hFD,
  parameter logic [7:0]  ERR_CODE      = 8'hFE,
  parameter logic [7:0]  PREAMBLE_CODE = 8'h55,
  parameter logic [7:0]  SFD_CODE      = 8'hD5
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [15:0]          i_len,
  input  logic [1:0]           i_mode,
  input  logic [7:0]           i_seed,
  input  logic                 i_abort,
  output logic [8*LANES-1:0]   o_tx_data,
  output logic [LANES-1:0]     o_tx_ctrl,
  output logic                 o_busy,
  output logic [15:0]          o_frame_cnt
);

  localparam int unsigned NL      = LANES;
  localparam logic [15:0] LANES_W = 16'(LANES);
  localparam logic [15:0] MIN_W   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_W   = 16'(MAX_LEN);
  localparam logic [15:0] IPG_W   = 16'(IPG_BYTES);
  localparam logic [15:0] HDR_W   = 16'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_TERM,
    ST_IPG
  } state_t;

  typedef enum logic [1:0] {
    PAT_INC   = 2'd0,
    PAT_CONST = 2'd1,
    PAT_PRBS  = 2'd2
  } pattern_t;

  // x^8+x^6+x^5+x^4+1, Fibonacci form, shifting toward the MSB
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [15:0] clamp_len(input logic [15:0] l);
    if (l < MIN_W) return MIN_W;
    if (l > MAX_W) return MAX_W;
    return l;
  endfunction

  // state and per-frame context; pos_q is the frame byte index of lane 0
  // of the word currently being composed
  state_t                state_q, state_d;
  logic     [15:0]       pos_q, pos_d;
  logic     [15:0]       len_q, len_d;
  pattern_t              pat_q, pat_d;
  logic     [7:0]        seed_q, seed_d;
  logic     [7:0]        lfsr_q, lfsr_d;
  logic     [15:0]       ipg_q, ipg_d;
  logic     [15:0]       frame_cnt_q, frame_cnt_d;
  logic     [8*LANES-1:0] tx_data_q, tx_data_d;
  logic     [LANES-1:0]  tx_ctrl_q, tx_ctrl_d;
  logic                  busy_q, busy_d;

  // shared frame geometry
  logic     [15:0]       term_pos;
  logic                  abort_hit;
  logic                  start_word;

  // next-state scratch
  logic     [15:0]       word_end;
  logic     [15:0]       gap;
  logic                  gap_valid;
  logic                  launch;
  logic     [7:0]        lfsr_adv;

  // output scratch
  logic     [15:0]       lane_idx;
  logic     [7:0]        lane_lfsr;
  logic     [7:0]        payload;

  // state register: everything, including the outputs, is a flop
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      len_q       <= '0;
      pat_q       <= PAT_INC;
      seed_q      <= '0;
      lfsr_q      <= '0;
      ipg_q       <= '0;
      frame_cnt_q <= '0;
      tx_data_q   <= {LANES{IDLE_CODE}};
      tx_ctrl_q   <= '1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      len_q       <= len_d;
      pat_q       <= pat_d;
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      ipg_q       <= ipg_d;
      frame_cnt_q <= frame_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_ctrl_q   <= tx_ctrl_d;
      busy_q      <= busy_d;
    end
  end

  // frame geometry: terminate byte position, abort qualification, start word
  always_comb begin
    term_pos   = HDR_W + len_q;
    abort_hit  = i_abort && ((state_q == ST_PRE) || (state_q == ST_DATA));
    start_word = (state_q == ST_PRE) && (pos_q == '0) && !abort_hit;
  end

  // next-state and context update
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    len_d       = len_q;
    pat_d       = pat_q;
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    ipg_d       = ipg_q;
    frame_cnt_d = frame_cnt_q;
    word_end    = pos_q + LANES_W;
    gap         = '0;
    gap_valid   = 1'b0;
    launch      = 1'b0;

    lfsr_adv = lfsr_q;
    for (int unsigned j = 0; j < NL; j++) begin
      lfsr_adv = lfsr_step(lfsr_adv);
    end

    if (start_word) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        launch = i_start;
      end
      ST_PRE: begin
        if (abort_hit) begin
          gap_valid = 1'b1;
        end else begin
          pos_d = word_end;
          if (word_end == HDR_W) begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (abort_hit) begin
          gap_valid = 1'b1;
        end else if (term_pos < word_end) begin
          // terminate lands inside this word: its trailing idle lanes
          // already count toward the gap
          gap       = word_end - 16'd1 - term_pos;
          gap_valid = 1'b1;
        end else begin
          pos_d  = word_end;
          lfsr_d = lfsr_adv;
          if (term_pos == word_end) begin
            state_d = ST_TERM;
          end
        end
      end
      ST_TERM: begin
        gap       = LANES_W - 16'd1;
        gap_valid = 1'b1;
      end
      ST_IPG: begin
        gap       = ipg_q + LANES_W;
        gap_valid = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (gap_valid) begin
      ipg_d = gap;
      if (gap >= IPG_W) begin
        if (i_start) begin
          launch = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        state_d = ST_IPG;
      end
    end

    if (launch) begin
      state_d = ST_PRE;
      pos_d   = '0;
      ipg_d   = '0;
      len_d   = clamp_len(i_len);
      seed_d  = i_seed;
      lfsr_d  = (i_seed == 8'h00) ? 8'hFF : i_seed;
      unique case (i_mode)
        2'd1:    pat_d = PAT_CONST;
        2'd2:    pat_d = PAT_PRBS;
        default: pat_d = PAT_INC;
      endcase
    end
  end

  // output word composition for the current state
  always_comb begin
    tx_data_d = {LANES{IDLE_CODE}};
    tx_ctrl_d = '1;
    busy_d    = (state_q != ST_IDLE);
    lane_idx  = '0;
    lane_lfsr = lfsr_q;
    payload   = '0;

    if (abort_hit) begin
      tx_data_d = {LANES{ERR_CODE}};
      tx_ctrl_d = '1;
    end else if ((state_q == ST_PRE) || (state_q == ST_DATA) || (state_q == ST_TERM)) begin
      for (int unsigned j = 0; j < NL; j++) begin
        lane_idx = pos_q + 16'(j);
        unique case (pat_q)
          PAT_CONST: payload = seed_q;
          PAT_PRBS:  payload = lane_lfsr;
          default:   payload = seed_q + lane_idx[7:0] - 8'd8;
        endcase
        if (lane_idx == 16'd0) begin
          tx_data_d[8*j +: 8] = START_CODE;
          tx_ctrl_d[j]        = 1'b1;
        end else if (lane_idx < 16'd7) begin
          tx_data_d[8*j +: 8] = PREAMBLE_CODE;
          tx_ctrl_d[j]        = 1'b0;
        end else if (lane_idx == 16'd7) begin
          tx_data_d[8*j +: 8] = SFD_CODE;
          tx_ctrl_d[j]        = 1'b0;
        end else if (lane_idx < term_pos) begin
          tx_data_d[8*j +: 8] = payload;
          tx_ctrl_d[j]        = 1'b0;
        end else if (lane_idx == term_pos) begin
          tx_data_d[8*j +: 8] = TERM_CODE;
          tx_ctrl_d[j]        = 1'b1;
        end
        lane_lfsr = lfsr_step(lane_lfsr);
      end
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_ctrl   = tx_ctrl_q;
  assign o_busy      = busy_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: doc/xgmii_frame_generator.md
Name: xgmii_frame_generator

Overview:
- Parametrised, multi-lane successor of the single-byte MII frame generator.
- Emits complete Ethernet frames as XGMII-style words of LANES bytes per cycle, each byte with a per-lane control flag: start, preamble, SFD, payload, terminate, idle fill and a guaranteed inter-packet gap.
- Adds runtime payload length, selectable payload patterns, abort/error injection, back-to-back streaming and a frame counter.
- Drives the MII/BASE-R verification path as a stimulus source.

Parameters:
- LANES, 8, bytes per output word; legal values 1, 2, 4, 8. Lane 0 = bits [7:0], first in time.
- MIN_LEN, 46, minimum payload bytes; smaller requests are clamped up.
- MAX_LEN, 1500, maximum payload bytes; larger requests are clamped down.
- IPG_BYTES, 12, minimum idle bytes after the terminate byte.
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start control character.
- TERM_CODE, 8'hFD, terminate control character.
- ERR_CODE, 8'hFE, error control character.
- PREAMBLE_CODE, 8'h55, preamble data byte.
- SFD_CODE, 8'hD5, start-of-frame delimiter.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  level request; a frame begins whenever the generator is eligible and this is high
- i_len  in  16  payload length in bytes, latched at frame start
- i_mode  in  2  payload pattern, latched at frame start: 0 incrementing, 1 constant, 2 PRBS8, 3 reserved (treated as 0)
- i_seed  in  8  first byte (mode 0), constant (mode 1) or LFSR seed (mode 2)
- i_abort  in  1  abort the frame in progress with error characters
- o_tx_data  out  8*LANES  output data word
- o_tx_ctrl  out  LANES  per-lane control flag; 1 = control character
- o_busy  out  1  high from the Start word through the last IPG word
- o_frame_cnt  out  16  frames started since reset, wraps at 16'hFFFF

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - o_tx_data = LANES copies of IDLE_CODE; o_tx_ctrl = all ones.
  - o_busy = 0, o_frame_cnt = 0, FSM = IDLE, all counters cleared.
  - After release, nothing is emitted until i_start is sampled.
- All outputs are registered. i_start sampled high in IDLE at edge k puts the Start word on the outputs after edge k+1.
- Byte stream of one frame, lanes filled in order:
  - Byte 0: START_CODE, ctrl 1.
  - Bytes 1-6: PREAMBLE_CODE. Byte 7: SFD_CODE.
  - Bytes 8 .. 8+L-1: payload, where L = clamp(i_len, MIN_LEN, MAX_LEN).
  - Byte 8+L: TERM_CODE, ctrl 1.
  - Remaining lanes of the terminate word: IDLE_CODE, ctrl 1.
  - Every byte not listed as control has ctrl 0.
- Start is always in lane 0. When LANES < 8, the preamble spans 8/LANES words.
- Payload patterns:
  - Mode 0: byte n = i_seed + n, mod 256.
  - Mode 1: every byte = i_seed.
  - Mode 2: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1. Seed 0 is replaced by 8'hFF. Each byte is the current state, then the LFSR advances once. Advance LANES times per word.
- IPG:
  - Count idle bytes after the terminate byte, including the idle fill in the terminate word.
  - Emit whole idle words until the count is >= IPG_BYTES.
  - The generator is then eligible again. If i_start is high, the next Start word follows with no extra cycle.
- FSM states: IDLE -> PRE -> DATA -> TERM -> IPG -> (IDLE or PRE).
  - TERM is skipped when the terminate byte falls inside the last DATA word.
  - TERM is its own word when 8+L is a multiple of LANES (terminate in lane 0).
- o_frame_cnt increments on every emitted Start word, including frames later aborted.
- Abort:
  - i_abort sampled high in PRE or DATA makes the next word all lanes ERR_CODE, ctrl all ones.
  - No terminate follows. The generator enters IPG, counting from the lane after that error word, i.e. a full IPG_BYTES.
  - i_abort is ignored in IDLE, TERM and IPG.
- i_len, i_mode and i_seed changes mid-frame have no effect on the current frame.

Test Plan:
- LANES=8, i_len=46, mode 0, seed 0, i_start pulsed one cycle:
  - Word 0 data 64'hD5555555555555FB, ctrl 8'h01.
  - Words 1-5 carry payload bytes 00..27, ctrl 0.
  - Word 6 lanes 0-5 = 28..2D, lane 6 = FD, lane 7 = 07, ctrl 8'hC0.
  - Then idle words; o_busy drops after word 8; o_frame_cnt = 1.
- i_start held high, i_len=46: Start words repeat every 9 cycles (7 frame words + 2 IPG words); o_busy stays high throughout.
- i_len=48: word 7 = FD in lane 0 plus seven 07 bytes, ctrl 8'hFF; one further IPG word; next Start on cycle 9.
- i_len=10 -> frame identical to i_len=46; i_len=2000 -> 1500 payload bytes. Mode 1, seed 8'hA5: every payload byte A5. Mode 2, seed 0: first payload byte FF, then the LFSR sequence.
- i_abort pulsed during word 3: word 4 = all FE, ctrl 8'hFF; no FD anywhere; next Start no earlier than word 7.
- i_rst_n low mid-payload: outputs become all 07, ctrl all ones, o_busy 0, o_frame_cnt 0 without a clock edge; a fresh i_start restarts from the Start word.
